// File: rtl/wrr_burst_arbiter_pkg.sv
// Shared definitions for the weighted round-robin burst arbiter.
package wrr_burst_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int ID_W   = 3;   // fits up to 8 requesters
    localparam int QW_DEF = 8;

    // Next round-robin start position after requester v, wrapping at n.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v, input int n);
        if (int'(v) >= n - 1)
            return '0;
        return v + ID_W'(1);
    endfunction

endpackage

// File: rtl/wrr_burst_arbiter_rr_pick.sv
// Rotating-priority encoder: first set REQ bit scanning PTR, PTR+1, ... mod N.
module rr_pick
    import wrr_burst_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]    REQ,
    input  logic [ID_W-1:0] PTR,
    output logic            FOUND,
    output logic [ID_W-1:0] IDX
);

    // Walk from the farthest offset down to offset 0 so the nearest hit wins.
    always_comb begin
        int j;
        j     = 0;
        FOUND = 1'b0;
        IDX   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(PTR) + k) % N;
            if (REQ[j]) begin
                FOUND = 1'b1;
                IDX   = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter feeding a single write port.
// IDLE spends one cycle picking a source; BURST pops up to QUOTA words from it.
module wrr_burst_arbiter
    import wrr_burst_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 32,
    parameter int QW = QW_DEF
) (
    input  logic              BUS_CLK,
    input  logic              BUS_RST,
    input  logic              ENABLE,
    input  logic [N*QW-1:0]   QUOTA,
    input  logic [N-1:0]      WRITE_REQ,
    input  logic [N*DW-1:0]   DATA_IN,
    output logic [N-1:0]      READ_GRANT,
    input  logic              READY_IN,
    output logic              WRITE_OUT,
    output logic [DW-1:0]     DATA_OUT,
    output logic [ID_W-1:0]   GRANT_ID,
    output logic              BUSY
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] gid_q, gid_d;
    logic [QW:0]     cnt_q, cnt_d;     // one extra bit so a zero quota can mean 2^QW
    logic            wr_q, wr_d;
    logic [DW-1:0]   dout_q, dout_d;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            req_g;
    logic [DW-1:0]   data_g;
    logic [QW-1:0]   quota_sel;
    logic            pop;

    rr_pick #(.N(N)) u_pick (
        .REQ   (WRITE_REQ),
        .PTR   (ptr_q),
        .FOUND (pick_found),
        .IDX   (pick_idx)
    );

    // Select the granted source's request/data and the candidate's quota.
    always_comb begin
        req_g     = 1'b0;
        data_g    = '0;
        quota_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (gid_q == ID_W'(i)) begin
                req_g  = WRITE_REQ[i];
                data_g = DATA_IN[i*DW +: DW];
            end
            if (pick_idx == ID_W'(i))
                quota_sel = QUOTA[i*QW +: QW];
        end
    end

    assign pop = (state_q == ST_BURST) && req_g && READY_IN;

    // One-hot pop strobe back to the granted source only.
    always_comb begin
        READ_GRANT = '0;
        for (int i = 0; i < N; i++)
            READ_GRANT[i] = pop && (gid_q == ID_W'(i));
    end

    // Next-state: selection in IDLE, word counting and burst termination in BURST.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        wr_d    = pop;
        dout_d  = pop ? data_g : dout_q;
        case (state_q)
            ST_IDLE: begin
                if (ENABLE && pick_found) begin
                    state_d = ST_BURST;
                    gid_d   = pick_idx;
                    cnt_d   = (quota_sel == '0) ? {1'b1, {QW{1'b0}}} : {1'b0, quota_sel};
                end
            end
            ST_BURST: begin
                if (pop)
                    cnt_d = cnt_q - (QW+1)'(1);
                // An empty source ends the burst even while downstream is stalled.
                if (!req_g || (pop && cnt_q == (QW+1)'(1))) begin
                    state_d = ST_IDLE;
                    ptr_d   = wrap_inc(gid_q, N);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
        end
    end

    assign WRITE_OUT = wr_q;
    assign DATA_OUT  = dout_q;
    assign GRANT_ID  = gid_q;
    assign BUSY      = (state_q == ST_BURST);

endmodule
